// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I sequencing controller: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and decodes every datapath enable and mux select.
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM    = 4'd4,
        S_WB     = 4'd5,
        S_TRAP   = 4'd6
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t     state;
    logic [6:0] op_q;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            op_q  <= '0;
        end else begin
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= opcode;
                    state <= is_legal(opcode) ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_LOAD, OP_STORE: state <= S_MEM;
                        OP_BRANCH:         state <= S_FETCH;
                        default:           state <= S_WB;
                    endcase
                end
                S_MEM:    if (mem_ready) state <= (op_q == OP_LOAD) ? S_WB : S_FETCH;
                S_WB:     state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs are decoded combinationally: FETCH must raise ir_write/pc_write
    // in the very cycle memory reports ready, so a registered copy would lag.
    always_comb begin
        // NOTE: every output gets a default before the case so no path
        // leaves a value unassigned, which would infer a latch.
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'b00;
        ir_write      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        wb_sel        = 2'b00;
        illegal_op    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    alu_src_b = 2'b01;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b10;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R:      begin alu_src_a = 2'b01; alu_op = 2'b10; end
                    OP_I:      begin alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = 2'b10; end
                    OP_LOAD,
                    OP_STORE:  begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
                    OP_BRANCH: begin
                        alu_src_a     = 2'b01;
                        alu_op        = 2'b01;
                        pc_write_cond = 1'b1;
                        pc_src        = 2'b01;
                    end
                    OP_JAL:    begin pc_write = 1'b1; pc_src = 2'b01; end
                    OP_JALR:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; pc_write = 1'b1; end
                    OP_LUI:    begin alu_src_a = 2'b10; alu_src_b = 2'b10; end
                    OP_AUIPC:  begin alu_src_a = 2'b11; alu_src_b = 2'b10; end
                    default:   ;
                endcase
            end
            S_MEM: begin
                mem_read  = (op_q == OP_LOAD);
                mem_write = (op_q == OP_STORE);
            end
            S_WB: begin
                reg_write = 1'b1;
                if (op_q == OP_LOAD)                          wb_sel = 2'b01;
                else if (op_q == OP_JAL || op_q == OP_JALR)   wb_sel = 2'b10;
            end
            S_TRAP:  illegal_op = 1'b1;
            default: ;
        endcase
    end

    assign state_o = state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: builds each instruction's expected per-cycle output
// trace from the opcode class and wait-state schedule, then compares.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal_op;
    logic [1:0] pc_src, alu_src_a, alu_src_b, alu_op, wb_sel;
    logic [3:0] state_o;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       illegal_op;
        logic [3:0] state;
    } obs_t;

    localparam logic [6:0] LEGAL [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                         7'b0010111};

    int   n_checks = 0;
    int   n_passed = 0;
    obs_t act;

    multicycle_control_fsm dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .wb_sel(wb_sel), .illegal_op(illegal_op), .state_o(state_o)
    );

    assign act = {pc_write, pc_write_cond, pc_src, ir_write, mem_read, mem_write,
                  reg_write, alu_src_a, alu_src_b, alu_op, wb_sel, illegal_op, state_o};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One cycle: drive mem_ready on the falling edge, compare just after.
    task automatic cyc(input logic mr, input obs_t e, input string tag);
        @(negedge clk);
        mem_ready = mr;
        #1;
        check(tag, 32'(act), 32'(e));
    endtask

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit legal(input logic [6:0] op);
        foreach (LEGAL[i]) if (LEGAL[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic obs_t idle_e();
        obs_t e = '0;
        return e;
    endfunction

    task automatic hold_reset(input int n);
        reset = 1'b1;
        repeat (n) cyc(rnd_bit(), idle_e(), "reset_idle");
        reset = 1'b0;
    endtask

    // Walks one instruction with fw FETCH and mw MEM wait cycles; abort
    // resets after the first MEM cycle instead of completing.
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input bit abort);
        obs_t e;
        opcode = op;
        for (int i = 0; i < fw; i++) begin
            e = '0; e.state = 4'd1; e.mem_read = 1'b1;
            cyc(1'b0, e, "fetch_wait");
        end
        e = '0; e.state = 4'd1; e.mem_read = 1'b1; e.ir_write = 1'b1;
        e.pc_write = 1'b1; e.alu_src_b = 2'b01;
        cyc(1'b1, e, "fetch_ready");

        e = '0; e.state = 4'd2; e.alu_src_a = 2'b11; e.alu_src_b = 2'b10;
        cyc(rnd_bit(), e, "decode");

        if (!legal(op)) begin
            e = '0; e.state = 4'd6; e.illegal_op = 1'b1;
            repeat (20) cyc(rnd_bit(), e, "trap_hold");
            hold_reset(1);
            return;
        end

        e = '0; e.state = 4'd3;
        case (op)
            7'b0110011: begin e.alu_src_a = 1; e.alu_op = 2; end
            7'b0010011: begin e.alu_src_a = 1; e.alu_src_b = 2; e.alu_op = 2; end
            7'b0000011,
            7'b0100011: begin e.alu_src_a = 1; e.alu_src_b = 2; end
            7'b1100011: begin e.alu_src_a = 1; e.alu_op = 1; e.pc_write_cond = 1; e.pc_src = 1; end
            7'b1101111: begin e.pc_write = 1; e.pc_src = 1; end
            7'b1100111: begin e.alu_src_a = 1; e.alu_src_b = 2; e.pc_write = 1; end
            7'b0110111: begin e.alu_src_a = 2; e.alu_src_b = 2; end
            default:    begin e.alu_src_a = 3; e.alu_src_b = 2; end
        endcase
        cyc(rnd_bit(), e, "exec");
        if (op == 7'b1100011) return;

        if (op == 7'b0000011 || op == 7'b0100011) begin
            e = '0; e.state = 4'd4;
            e.mem_read  = (op == 7'b0000011);
            e.mem_write = (op == 7'b0100011);
            if (abort) begin
                cyc(1'b0, e, "mem_before_abort");
                hold_reset(3);
                return;
            end
            for (int i = 0; i < mw; i++) cyc(1'b0, e, "mem_wait");
            cyc(1'b1, e, "mem_ready");
            if (op == 7'b0100011) return;
        end

        e = '0; e.state = 4'd5; e.reg_write = 1'b1;
        if (op == 7'b0000011)                         e.wb_sel = 2'b01;
        else if (op == 7'b1101111 || op == 7'b1100111) e.wb_sel = 2'b10;
        cyc(rnd_bit(), e, "wb");
    endtask

    initial begin
        logic [6:0] op;
        reset = 1'b1;
        mem_ready = 1'b0;
        opcode = '0;
        hold_reset(3);

        run_instr(7'b0000011, 0, 0, 1'b1);   // reset aborts a LOAD mid-MEM
        run_instr(7'b0110011, 0, 0, 1'b0);
        run_instr(7'b0000011, 2, 3, 1'b0);
        run_instr(7'b0100011, 0, 0, 1'b0);
        run_instr(7'b1100011, 0, 0, 1'b0);
        run_instr(7'b1101111, 0, 0, 1'b0);
        run_instr(7'b1111111, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 7'($urandom_range(0, 127)); while (legal(op));
            end else begin
                op = LEGAL[$urandom_range(0, 8)];
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                      $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
